// File: rtl/mux_4x1_lane_sequencer.sv
// Lane sequencer: captures a LANES-wide word on load and presents one lane per valid/ready beat.
// Optional trailing XOR-parity beat is compiled in with LANE_SEQ_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a load; load_ready high
// SEND   | presenting shadow lane idx on out_data
// PARITY | presenting XOR of all lanes (LANE_SEQ_PARITY_EN only)
module mux_4x1_lane_sequencer #(
    parameter  int LANES = 4,
    parameter  int W     = 1,
    localparam int SW    = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [LANES*W-1:0] x_in,
    output logic [SW-1:0]      s_out,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

`ifdef LANE_SEQ_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    localparam logic [SW-1:0] LAST_IDX = SW'(LANES - 1);

    state_t               state, state_nxt;
    logic [SW-1:0]        idx, idx_nxt;
    logic [LANES*W-1:0]   shadow, shadow_nxt;
    logic [W-1:0]         lane_word;
    logic [W-1:0]         parity_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
        end
    end

    // Lane mux and parity both read only the shadow, never x_in.
    always_comb begin
        lane_word   = '0;
        parity_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (SW'(i) == idx)
                lane_word = shadow[i*W +: W];
            parity_word = parity_word ^ shadow[i*W +: W];
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    shadow_nxt = x_in;
                    idx_nxt    = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
`ifdef LANE_SEQ_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
`ifdef LANE_SEQ_PARITY_EN
            PARITY: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only; reset gates load_ready during the reset cycle.
    always_comb begin
        s_out      = idx;
        out_valid  = (state != IDLE);
        busy       = (state != IDLE);
        load_ready = (state == IDLE) && !reset;
`ifdef LANE_SEQ_PARITY_EN
        out_last   = (state == PARITY);
        out_data   = (state == PARITY) ? parity_word : lane_word;
`else
        out_last   = (state == SEND) && (idx == LAST_IDX);
        out_data   = lane_word;
`endif
    end

endmodule

// File: tb/tb_mux_4x1_lane_sequencer.sv
// Directed bench for mux_4x1_lane_sequencer: table of per-cycle vectors (W=1)
// plus hand sequences for back-to-back frames and a W=4 frame (parity when LANE_SEQ_PARITY_EN).
module tb_mux_4x1_lane_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // W=1 instance
    logic       reset, load_valid, load_ready, out_valid, out_ready, out_last, busy;
    logic [3:0] x_in;
    logic [1:0] s_out;
    logic [0:0] out_data;

    // W=4 instance
    logic        w4_reset, w4_load_valid, w4_load_ready, w4_out_valid, w4_out_ready, w4_out_last, w4_busy;
    logic [15:0] w4_x_in;
    logic [1:0]  w4_s_out;
    logic [3:0]  w4_out_data;

    mux_4x1_lane_sequencer #(.LANES(4), .W(1)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .x_in(x_in), .s_out(s_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    mux_4x1_lane_sequencer #(.LANES(4), .W(4)) u_dut4 (
        .clk(clk), .reset(w4_reset), .load_valid(w4_load_valid), .load_ready(w4_load_ready),
        .x_in(w4_x_in), .s_out(w4_s_out), .out_data(w4_out_data), .out_valid(w4_out_valid),
        .out_ready(w4_out_ready), .out_last(w4_out_last), .busy(w4_busy)
    );

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] x;
        logic       ordy;
        logic [1:0] s;
        logic       d;
        logic       v;
        logic       last;
        logic       lr;
        logic       bsy;
    } vec_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[23];
        logic [3:0]  pat;
        logic [3:0]  exp_w4 [5];
        logic [3:0]  got_d  [8];
        logic        got_l  [8];
        int          nb, n_exp;
        logic        done;

        reset = 1'b1; load_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        w4_reset = 1'b1; w4_load_valid = 1'b0; w4_x_in = '0; w4_out_ready = 1'b0;

`ifndef LANE_SEQ_PARITY_EN
        //            rst  lv   x     ordy   s     d     v     last  lr    bsy
        tv[0]  = '{1'b1,1'b0,4'h0,1'b0, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tv[1]  = '{1'b0,1'b1,4'hA,1'b1, 2'd0,1'b0,1'b1,1'b0,1'b0,1'b1};
        tv[2]  = '{1'b0,1'b0,4'hA,1'b1, 2'd1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[3]  = '{1'b0,1'b0,4'h0,1'b1, 2'd2,1'b0,1'b1,1'b0,1'b0,1'b1};
        tv[4]  = '{1'b0,1'b0,4'h0,1'b1, 2'd3,1'b1,1'b1,1'b1,1'b0,1'b1};
        tv[5]  = '{1'b0,1'b0,4'h0,1'b1, 2'd3,1'b1,1'b0,1'b0,1'b1,1'b0};
        tv[6]  = '{1'b0,1'b1,4'h6,1'b0, 2'd0,1'b0,1'b1,1'b0,1'b0,1'b1};
        tv[7]  = '{1'b0,1'b0,4'h6,1'b1, 2'd1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[8]  = '{1'b0,1'b0,4'h6,1'b1, 2'd2,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[9]  = '{1'b0,1'b0,4'h6,1'b0, 2'd2,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[10] = '{1'b0,1'b0,4'h6,1'b0, 2'd2,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[11] = '{1'b0,1'b1,4'hF,1'b0, 2'd2,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[12] = '{1'b0,1'b0,4'hF,1'b1, 2'd3,1'b0,1'b1,1'b1,1'b0,1'b1};
        tv[13] = '{1'b0,1'b1,4'h3,1'b1, 2'd3,1'b0,1'b0,1'b0,1'b1,1'b0};
        tv[14] = '{1'b0,1'b1,4'h3,1'b1, 2'd0,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[15] = '{1'b0,1'b0,4'h3,1'b1, 2'd1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[16] = '{1'b1,1'b0,4'h3,1'b1, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tv[17] = '{1'b0,1'b0,4'h3,1'b1, 2'd0,1'b0,1'b0,1'b0,1'b1,1'b0};
        tv[18] = '{1'b0,1'b1,4'h6,1'b1, 2'd0,1'b0,1'b1,1'b0,1'b0,1'b1};
        tv[19] = '{1'b0,1'b0,4'h6,1'b1, 2'd1,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[20] = '{1'b0,1'b0,4'h6,1'b1, 2'd2,1'b1,1'b1,1'b0,1'b0,1'b1};
        tv[21] = '{1'b0,1'b0,4'h6,1'b1, 2'd3,1'b0,1'b1,1'b1,1'b0,1'b1};
        tv[22] = '{1'b0,1'b0,4'h6,1'b1, 2'd3,1'b0,1'b0,1'b0,1'b1,1'b0};

        for (int i = 0; i < 23; i++) begin
            reset = tv[i].rst; load_valid = tv[i].lv; x_in = tv[i].x; out_ready = tv[i].ordy;
            tick();
            chk($sformatf("v%0d s_out", i),      32'(s_out),      32'(tv[i].s));
            chk($sformatf("v%0d out_data", i),   32'(out_data),   32'(tv[i].d));
            chk($sformatf("v%0d out_valid", i),  32'(out_valid),  32'(tv[i].v));
            chk($sformatf("v%0d out_last", i),   32'(out_last),   32'(tv[i].last));
            chk($sformatf("v%0d load_ready", i), 32'(load_ready), 32'(tv[i].lr));
            chk($sformatf("v%0d busy", i),       32'(busy),       32'(tv[i].bsy));
        end

        // Back-to-back loads with load_valid held: 4 beats, 1 idle, repeat.
        pat = 4'b1001;
        load_valid = 1'b1; x_in = pat; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("b2b c%0d out_valid", c), 32'(out_valid), 32'((c % 5) != 4));
            if ((c % 5) != 4) begin
                chk($sformatf("b2b c%0d s_out", c),    32'(s_out),    32'(c % 5));
                chk($sformatf("b2b c%0d out_data", c), 32'(out_data), 32'(pat[c % 5]));
            end
        end
        load_valid = 1'b0;
`endif

        // W=4 frame: lanes 3,5,9,0; parity beat F when compiled in.
        exp_w4[0] = 4'h3; exp_w4[1] = 4'h5; exp_w4[2] = 4'h9; exp_w4[3] = 4'h0; exp_w4[4] = 4'hF;
`ifdef LANE_SEQ_PARITY_EN
        n_exp = 5;
`else
        n_exp = 4;
`endif
        tick();
        w4_reset = 1'b0;
        chk("w4 reset load_ready", 32'(w4_load_ready), 32'd1);
        w4_load_valid = 1'b1; w4_x_in = 16'h0953; w4_out_ready = 1'b1;
        tick();
        w4_load_valid = 1'b0;
        nb = 0; done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (w4_out_valid && w4_out_ready && nb < 8) begin
                got_d[nb] = w4_out_data;
                got_l[nb] = w4_out_last;
                done = w4_out_last;
                nb++;
            end
            tick();
        end
        chk("w4 frame terminated", 32'(done), 32'd1);
        chk("w4 beat count", 32'(nb), 32'(n_exp));
        for (int k = 0; k < n_exp && k < nb; k++) begin
            chk($sformatf("w4 beat%0d data", k), 32'(got_d[k]), 32'(exp_w4[k]));
            chk($sformatf("w4 beat%0d last", k), 32'(got_l[k]), 32'(k == n_exp - 1));
        end
        chk("w4 idle after frame", 32'(w4_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mux_4x1_lane_sequencer.md
# mux_4x1_lane_sequencer

Upstream control stage for the 4-to-1 multiplexer path. It captures a parallel word of LANES lanes on a load handshake, then drives the lane select and presents one lane per beat on a valid/ready output. The result is a time-division serial stream for downstream consumers. It replaces hand-driven select lines with a registered, back-pressure-aware sequencer.

## Interface
- LANES, 4: number of lanes per frame; must be a power of two, ≥ 2.
- W, 1: width of each lane in bits.
- SW, $clog2(LANES): select width (derived; not overridden).

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  parallel word on x_in is valid.
- load_ready  output  1  sequencer can accept a word; high only in IDLE.
- x_in  input  LANES*W  parallel word; lane i at bits [i*W +: W].
- s_out  output  SW  current lane select (registered index).
- out_data  output  W  selected lane (or parity word, see Configuration).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current beat.
- out_last  output  1  current beat is the final beat of the frame.
- busy  output  1  frame in progress (state ≠ IDLE).

## Operation
- Shadow register holds the captured word; out_data = shadow lane s_out (registered source, no path from x_in to out_data).
- FSM states: IDLE, SEND, plus PARITY when compiled in.
- IDLE: load_ready=1, out_valid=0. When load_valid=1, shadow←x_in, idx←0, go to SEND.
- SEND: out_valid=1. When out_ready=1:
  - if idx<LANES-1: idx←idx+1.
  - if idx=LANES-1: go to PARITY (macro defined) or IDLE.
- out_last=1 in SEND at idx=LANES-1 without the macro; with it, out_last=1 only in PARITY.
- A handshake fires only when out_valid=1 and out_ready=1. Otherwise out_data, s_out and out_last hold stable.
- load_valid is ignored outside IDLE; x_in changes mid-frame do not affect the frame.
- Reset values: state=IDLE, idx=0, shadow=0, s_out=0, out_data=0, out_valid=0, out_last=0, busy=0, load_ready=0 during the reset cycle, then 1.
- Reset mid-frame: the frame is abandoned and no further beats are issued. The first cycle after reset deasserts is IDLE.

## Timing
- Load accepted at edge N → out_valid=1, s_out=0 in cycle N+1.
- With out_ready held high, a frame takes LANES beats (LANES+1 with parity) in consecutive cycles. Then one IDLE cycle before the next load.
- Maximum throughput: one frame per LANES+1 cycles (LANES+2 with parity).
- idx wraps to 0 only via IDLE and a new load; it never increments past LANES-1.
- No combinational path from out_ready or load_valid to any output.

## Configuration
- LANE_SEQ_PARITY_EN defined: after lane LANES-1 the FSM enters PARITY for one beat. That beat has out_data = bitwise XOR of all LANES lanes and s_out = LANES-1 (held). out_last=1 in this beat, and the handshake returns the FSM to IDLE.
- Undefined: there is no PARITY state, frames are exactly LANES beats, and out_last marks lane LANES-1.

## Test plan
- Reset then load x_in=4'b1010 (W=1) with out_ready=1 → out_data sequence 0,1,0,1 on s_out 0,1,2,3; out_last on the 4th beat; load_ready=1 one cycle later.
- Back-pressure: out_ready=0 for 3 cycles at s_out=2 → out_data, s_out, out_valid and out_last are stable, then the frame resumes at lane 2 with no beat lost or duplicated.
- Load ignored while busy: pulse load_valid with x_in=4'b1111 mid-frame → the current frame's data is unchanged and load_ready stays 0.
- Reset asserted at s_out=1 → next cycle out_valid=0, s_out=0, out_data=0, busy=0; a following load of 4'b0110 produces a clean frame 0,1,1,0.
- LANE_SEQ_PARITY_EN, W=4, lanes 4'h3,4'h5,4'h9,4'h0 → 5 beats, final beat 4'hF with out_last=1.
- LANE_SEQ_PARITY_EN undefined, two loads issued back-to-back → exactly one IDLE cycle separates the frames.
